gun_position_ctrl: RTL and testbench

- Multi-channel gun-sight position generator for the Williams 2 light-gun titles.
- Converts per-player joystick directions or signed analog sticks into saturating POS_W-bit horizontal/vertical gun coordinates.
- Sits between the hps_io joystick decode and the williams2 gun_h/gun_v inputs.
- Paced by the game's 4 ms tick (cnt_4ms_o), which it receives on tick_in.
- Generalises a fixed single-speed, single-player counter to N channels, configurable bounds, acceleration, and an absolute analog mode.

---
 rtl/gun_position_ctrl.sv | 169 ++++++++++++++++
 tb/tb_gun_position_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gun_position_ctrl.sv
// gun_position_ctrl
// Multi-channel light-gun sight generator for the Williams 2 gun titles.
// Each channel holds a horizontal and a vertical coordinate. The coordinates
// are moved by joystick directions (with acceleration after a long hold) or
// set directly from a signed analog stick. Updates happen once per rising
// edge of the game's 4 ms pacing tick.

module gun_position_ctrl #(
    parameter int CHANNELS    = 2,
    parameter int POS_W       = 6,
    parameter int H_MIN       = 0,
    parameter int H_MAX       = 63,
    parameter int V_MIN       = 0,
    parameter int V_MAX       = 63,
    parameter int SLOW_STEP   = 1,
    parameter int FAST_STEP   = 2,
    parameter int ACCEL_TICKS = 16
) (
    input  logic                      clock_12,
    input  logic                      reset,
    input  logic                      tick_in,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       recenter,
    input  logic [CHANNELS-1:0]       dir_up,
    input  logic [CHANNELS-1:0]       dir_down,
    input  logic [CHANNELS-1:0]       dir_left,
    input  logic [CHANNELS-1:0]       dir_right,
    input  logic [CHANNELS*8-1:0]     analog_h,
    input  logic [CHANNELS*8-1:0]     analog_v,
    output logic [CHANNELS*POS_W-1:0] gun_h,
    output logic [CHANNELS*POS_W-1:0] gun_v,
    output logic [CHANNELS-1:0]       moving
);

    // Hold counter saturates at ACCEL_TICKS, so it needs clog2(ACCEL_TICKS+1) bits.
    localparam int HW = $clog2(ACCEL_TICKS + 1);
    // Extended width for step arithmetic: wide enough that MIN+step and
    // pos+step never wrap, so saturation compares are exact.
    localparam int EW = POS_W + 10;
    // Analog scaling product width: 8-bit stick times an EW-bit range.
    localparam int PW = EW + 8;

    localparam logic [EW-1:0]    H_MIN_E   = EW'(H_MIN);
    localparam logic [EW-1:0]    H_MAX_E   = EW'(H_MAX);
    localparam logic [EW-1:0]    V_MIN_E   = EW'(V_MIN);
    localparam logic [EW-1:0]    V_MAX_E   = EW'(V_MAX);
    localparam logic [EW-1:0]    H_RANGE   = EW'(H_MAX - H_MIN + 1);
    localparam logic [EW-1:0]    V_RANGE   = EW'(V_MAX - V_MIN + 1);
    localparam logic [EW-1:0]    SLOW_E    = EW'(SLOW_STEP);
    localparam logic [EW-1:0]    FAST_E    = EW'(FAST_STEP);
    localparam logic [HW-1:0]    ACCEL_E   = HW'(ACCEL_TICKS);
    localparam logic [POS_W-1:0] H_C       = POS_W'((H_MIN + H_MAX) >> 1);
    localparam logic [POS_W-1:0] V_C       = POS_W'((V_MIN + V_MAX) >> 1);

    logic                             tick_q;
    logic                             upd;
    logic [CHANNELS-1:0][POS_W-1:0]   hPos_q, hPos_d;
    logic [CHANNELS-1:0][POS_W-1:0]   vPos_q, vPos_d;
    logic [CHANNELS-1:0][HW-1:0]      hHold_q, hHold_d;
    logic [CHANNELS-1:0][HW-1:0]      vHold_q, vHold_d;
    logic [CHANNELS-1:0]              moving_q, moving_d;

    // One relative step toward MIN (dec=1) or MAX (dec=0), clamped at the bound.
    function automatic logic [POS_W-1:0] moveAxis(
        input logic [POS_W-1:0] pos,
        input logic             dec,
        input logic             fast,
        input logic [EW-1:0]    minE,
        input logic [EW-1:0]    maxE
    );
        logic [EW-1:0] p;
        logic [EW-1:0] s;
        logic [EW-1:0] r;
        p = EW'(pos);
        s = fast ? FAST_E : SLOW_E;
        if (dec) begin
            r = (p < minE + s) ? minE : p - s;
        end else begin
            r = (p + s > maxE) ? maxE : p + s;
        end
        return POS_W'(r);
    endfunction

    // Hold counter increment that sticks at ACCEL_TICKS.
    function automatic logic [HW-1:0] nextHold(input logic [HW-1:0] h);
        return (h >= ACCEL_E) ? ACCEL_E : h + HW'(1);
    endfunction

    // Map a signed stick value onto MIN..MAX by offset-binary scaling.
    function automatic logic [POS_W-1:0] analogPos(
        input logic [7:0]    a,
        input logic [EW-1:0] minE,
        input logic [EW-1:0] range
    );
        logic [7:0]    u;
        logic [PW-1:0] prod;
        logic [PW-1:0] r;
        u    = a ^ 8'h80;
        prod = PW'(u) * PW'(range);
        r    = PW'(minE) + (prod >> 8);
        return POS_W'(r);
    endfunction

    assign upd   = tick_in & ~tick_q;
    assign gun_h = hPos_q;
    assign gun_v = vPos_q;
    assign moving = moving_q;

    // Next-state for every channel: recenter wins over a tick update.
    always_comb begin
        hPos_d   = hPos_q;
        vPos_d   = vPos_q;
        hHold_d  = hHold_q;
        vHold_d  = vHold_q;
        moving_d = moving_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (recenter[c]) begin
                hPos_d[c]   = H_C;
                vPos_d[c]   = V_C;
                hHold_d[c]  = '0;
                vHold_d[c]  = '0;
                moving_d[c] = (hPos_q[c] != H_C) || (vPos_q[c] != V_C);
            end else if (upd) begin
                if (mode[c]) begin
                    hPos_d[c]  = analogPos(analog_h[8*c +: 8], H_MIN_E, H_RANGE);
                    vPos_d[c]  = analogPos(analog_v[8*c +: 8], V_MIN_E, V_RANGE);
                    hHold_d[c] = '0;
                    vHold_d[c] = '0;
                end else begin
                    if (dir_left[c] ^ dir_right[c]) begin
                        hPos_d[c]  = moveAxis(hPos_q[c], dir_left[c],
                                              hHold_q[c] >= ACCEL_E, H_MIN_E, H_MAX_E);
                        hHold_d[c] = nextHold(hHold_q[c]);
                    end else begin
                        hHold_d[c] = '0;
                    end
                    if (dir_up[c] ^ dir_down[c]) begin
                        vPos_d[c]  = moveAxis(vPos_q[c], dir_up[c],
                                              vHold_q[c] >= ACCEL_E, V_MIN_E, V_MAX_E);
                        vHold_d[c] = nextHold(vHold_q[c]);
                    end else begin
                        vHold_d[c] = '0;
                    end
                end
                moving_d[c] = (hPos_d[c] != hPos_q[c]) || (vPos_d[c] != vPos_q[c]);
            end
        end
    end

    // State registers; reset puts every sight back at centre and clears acceleration.
    always_ff @(posedge clock_12) begin
        if (reset) begin
            tick_q   <= 1'b0;
            hPos_q   <= {CHANNELS{H_C}};
            vPos_q   <= {CHANNELS{V_C}};
            hHold_q  <= '0;
            vHold_q  <= '0;
            moving_q <= '0;
        end else begin
            tick_q   <= tick_in;
            hPos_q   <= hPos_d;
            vPos_q   <= vPos_d;
            hHold_q  <= hHold_d;
            vHold_q  <= vHold_d;
            moving_q <= moving_d;
        end
    end

endmodule

// File: tb/tb_gun_position_ctrl.sv
// tb_gun_position_ctrl
// Directed bench for gun_position_ctrl with hand-computed expected positions.

module tb_gun_position_ctrl;

    localparam int CH = 2;
    localparam int PW = 6;

    logic              clock_12 = 1'b0;
    logic              reset;
    logic              tick_in;
    logic [CH-1:0]     mode, recenter, dir_up, dir_down, dir_left, dir_right;
    logic [CH*8-1:0]   analog_h, analog_v;
    logic [CH*PW-1:0]  gun_h, gun_v;
    logic [CH-1:0]     moving;

    int vectors = 0;
    int miscompares = 0;

    gun_position_ctrl dut (
        .clock_12  (clock_12),
        .reset     (reset),
        .tick_in   (tick_in),
        .mode      (mode),
        .recenter  (recenter),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .dir_left  (dir_left),
        .dir_right (dir_right),
        .analog_h  (analog_h),
        .analog_v  (analog_v),
        .gun_h     (gun_h),
        .gun_v     (gun_v),
        .moving    (moving)
    );

    // 12 MHz-ish free-running clock.
    always #5 clock_12 = ~clock_12;

    function automatic logic [7:0] gh(input int c);
        return 8'(gun_h[c*PW +: PW]);
    endfunction

    function automatic logic [7:0] gv(input int c);
        return 8'(gun_v[c*PW +: PW]);
    endfunction

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Issue n single-cycle tick pulses, each followed by a low cycle.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock_12) tick_in = 1'b1;
            @(negedge clock_12) tick_in = 1'b0;
        end
    endtask

    task automatic checkCh(input string tag, input int c, input logic [7:0] h,
                           input logic [7:0] v, input logic m);
        checkOutput({tag, "_h"}, gh(c), h);
        checkOutput({tag, "_v"}, gv(c), v);
        checkOutput({tag, "_mv"}, 8'(moving[c]), 8'(m));
    endtask

    initial begin
        reset = 1'b1; tick_in = 1'b0; mode = '0; recenter = '0;
        dir_up = '0; dir_down = '0; dir_left = '0; dir_right = '0;
        analog_h = '0; analog_v = '0;
        repeat (2) @(negedge clock_12);
        reset = 1'b0;
        checkCh("rst0", 0, 8'd31, 8'd31, 1'b0);
        checkCh("rst1", 1, 8'd31, 8'd31, 1'b0);

        // Idle ticks leave everything centred.
        applyStimulus(3);
        checkCh("idle0", 0, 8'd31, 8'd31, 1'b0);
        checkCh("idle1", 1, 8'd31, 8'd31, 1'b0);

        // Right held 20 ticks: 16 slow + 4 fast = 31+16+8.
        dir_right[0] = 1'b1;
        applyStimulus(20);
        checkCh("accel0", 0, 8'd55, 8'd31, 1'b1);
        checkCh("accel1", 1, 8'd31, 8'd31, 1'b0);

        // Keep pushing: saturates at 63, last update does not move.
        applyStimulus(40);
        checkCh("satHi", 0, 8'd63, 8'd31, 1'b0);

        // Release for a tick to clear hold, then left 39 ticks: 63-16-2*23 = 1.
        dir_right[0] = 1'b0;
        applyStimulus(1);
        dir_left[0] = 1'b1;
        applyStimulus(39);
        checkCh("leftTo1", 0, 8'd1, 8'd31, 1'b1);
        applyStimulus(1);
        checkCh("satLo", 0, 8'd0, 8'd31, 1'b1);
        applyStimulus(1);
        checkCh("noWrap", 0, 8'd0, 8'd31, 1'b0);
        dir_left[0] = 1'b0;

        // Opposing H cancels while V moves down 5.
        dir_left[1] = 1'b1; dir_right[1] = 1'b1; dir_down[1] = 1'b1;
        applyStimulus(5);
        checkCh("oppose1", 1, 8'd31, 8'd36, 1'b1);
        dir_left[1] = 1'b0; dir_down[1] = 1'b0;
        applyStimulus(1);
        checkCh("rightSlow1", 1, 8'd32, 8'd36, 1'b1);
        checkOutput("ch0Indep_h", gh(0), 8'd0);
        dir_right[1] = 1'b0;

        // Long-high tick gives exactly one update.
        @(negedge clock_12) begin tick_in = 1'b1; dir_up[1] = 1'b1; end
        checkOutput("preEdge_v1", gv(1), 8'd36);
        @(negedge clock_12);
        @(negedge clock_12);
        checkOutput("edge2clk_v1", gv(1), 8'd35);
        repeat (98) @(negedge clock_12);
        checkOutput("heldHigh_v1", gv(1), 8'd35);
        tick_in = 1'b0; dir_up[1] = 1'b0;

        // Analog absolute mode on channel 0; channel 1 ignores its sticks.
        mode[0] = 1'b1;
        analog_h = 16'h5580; analog_v = 16'h11C0;
        applyStimulus(1);
        checkCh("ana80", 0, 8'd0, 8'd16, 1'b1);
        checkOutput("anaIgnore1_h", gh(1), 8'd32);
        analog_h[7:0] = 8'h00;
        applyStimulus(1);
        checkCh("ana00", 0, 8'd32, 8'd16, 1'b1);
        analog_h[7:0] = 8'h7F; analog_v[7:0] = 8'h7F;
        applyStimulus(1);
        checkCh("ana7F", 0, 8'd63, 8'd63, 1'b1);

        // Recenter coinciding with a tick wins.
        @(negedge clock_12) begin recenter[0] = 1'b1; tick_in = 1'b1; end
        @(negedge clock_12) begin recenter[0] = 1'b0; tick_in = 1'b0; end
        checkCh("recenter", 0, 8'd31, 8'd31, 1'b1);

        // Reset in the middle of analog activity.
        applyStimulus(1);
        checkCh("anaAgain", 0, 8'd63, 8'd63, 1'b1);
        @(negedge clock_12) reset = 1'b1;
        @(negedge clock_12) reset = 1'b0;
        checkCh("midRst0", 0, 8'd31, 8'd31, 1'b0);
        checkCh("midRst1", 1, 8'd31, 8'd31, 1'b0);

        // Reset mid-hold drops acceleration: first tick after is slow.
        mode[0] = 1'b0; dir_right[0] = 1'b1;
        applyStimulus(20);
        checkOutput("preRstAccel_h", gh(0), 8'd55);
        @(negedge clock_12) reset = 1'b1;
        @(negedge clock_12) reset = 1'b0;
        applyStimulus(1);
        checkCh("postRstSlow", 0, 8'd32, 8'd31, 1'b1);
        dir_right[0] = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
